// File: rtl/wb_write_arbiter_if.sv
// Write-back bus between the WB stage, the write arbiter and the register-file write port.
// The slave modport is the arbiter's view of the bus.
interface wb_write_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              wb0_valid;
  logic [ADDR_W-1:0] wb0_reg;
  logic [DATA_W-1:0] wb0_data;
  logic              wb1_valid;
  logic [ADDR_W-1:0] wb1_reg;
  logic [DATA_W-1:0] wb1_data;
  logic              stall_wb;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] q0_addr;
  logic              q0_hit;
  logic [DATA_W-1:0] q0_data;
  logic [ADDR_W-1:0] q1_addr;
  logic              q1_hit;
  logic [DATA_W-1:0] q1_data;

  modport master (
    output wb0_valid, wb0_reg, wb0_data, wb1_valid, wb1_reg, wb1_data, q0_addr, q1_addr,
    input  stall_wb, rf_we, rf_waddr, rf_wdata, q0_hit, q0_data, q1_hit, q1_data
  );

  modport slave (
    input  wb0_valid, wb0_reg, wb0_data, wb1_valid, wb1_reg, wb1_data, q0_addr, q1_addr,
    output stall_wb, rf_we, rf_waddr, rf_wdata, q0_hit, q0_data, q1_hit, q1_data
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Serialises two write-back lanes onto one register-file write port through an in-order queue.
// Define WB_FWD_EN to build the pending-write forwarding lookup on the q0/q1 ports.
module wb_write_arbiter #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  wb_write_arbiter_if.slave   bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic              stall, eff0, eff1, pop;
  logic [1:0]        npush, enq_n;
  logic [ADDR_W-1:0] first_addr, enq0_addr, enq1_addr;
  logic [DATA_W-1:0] first_data, enq0_data, enq1_data;

  function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] p, input int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return PtrW'(s);
  endfunction

  // At most two pushes per cycle, so keep two free slots whenever WB is allowed to proceed.
  assign stall = (count_q > CntW'(DEPTH - 2));

  always_comb begin
    eff0 = bus.wb0_valid && (bus.wb0_reg != '0) && !stall;
    eff1 = bus.wb1_valid && (bus.wb1_reg != '0) && !stall;
    if (eff0 && eff1 && (bus.wb0_reg == bus.wb1_reg)) eff0 = 1'b0;
    npush      = {1'b0, eff0} + {1'b0, eff1};
    first_addr = eff0 ? bus.wb0_reg  : bus.wb1_reg;
    first_data = eff0 ? bus.wb0_data : bus.wb1_data;

    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    pop        = 1'b0;
    enq_n      = 2'd0;
    enq0_addr  = first_addr;
    enq0_data  = first_data;
    enq1_addr  = bus.wb1_reg;
    enq1_data  = bus.wb1_data;

    if (count_q != '0) begin
      pop        = 1'b1;
      rf_we_d    = 1'b1;
      rf_waddr_d = mem_addr[head_q];
      rf_wdata_d = mem_data[head_q];
      enq_n      = npush;
    end else if (npush != 2'd0) begin
      // Empty queue: the oldest new write bypasses straight into the output stage.
      rf_we_d    = 1'b1;
      rf_waddr_d = first_addr;
      rf_wdata_d = first_data;
      enq_n      = npush - 2'd1;
      enq0_addr  = bus.wb1_reg;
      enq0_data  = bus.wb1_data;
    end

    count_d = count_q + CntW'(enq_n) - CntW'(pop);
    head_d  = pop ? ptr_add(head_q, 1) : head_q;
    tail_d  = ptr_add(tail_q, 32'(enq_n));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Storage needs no reset: occupancy is defined solely by count_q.
  always_ff @(posedge clk_i) begin
    if (enq_n != 2'd0) begin
      mem_addr[tail_q] <= enq0_addr;
      mem_data[tail_q] <= enq0_data;
    end
    if (enq_n == 2'd2) begin
      mem_addr[ptr_add(tail_q, 1)] <= enq1_addr;
      mem_data[ptr_add(tail_q, 1)] <= enq1_data;
    end
  end

  assign bus.stall_wb = stall;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

`ifdef WB_FWD_EN
  logic [1:0][ADDR_W-1:0] fwd_addr;
  logic [1:0]             fwd_hit;
  logic [1:0][DATA_W-1:0] fwd_data;
  logic [PtrW-1:0]        idx;

  assign fwd_addr[0] = bus.q0_addr;
  assign fwd_addr[1] = bus.q1_addr;

  // Scan oldest to newest so the youngest matching write overrides earlier ones.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    idx      = '0;
    for (int p = 0; p < 2; p++) begin
      if (rf_we_q && (fwd_addr[p] == rf_waddr_q)) begin
        fwd_hit[p]  = 1'b1;
        fwd_data[p] = rf_wdata_q;
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        idx = ptr_add(head_q, 32'(i));
        if ((CntW'(i) < count_q) && (mem_addr[idx] == fwd_addr[p])) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = mem_data[idx];
        end
      end
      if (fwd_addr[p] == '0) begin
        fwd_hit[p]  = 1'b0;
        fwd_data[p] = '0;
      end
    end
  end

  assign bus.q0_hit  = fwd_hit[0];
  assign bus.q0_data = fwd_data[0];
  assign bus.q1_hit  = fwd_hit[1];
  assign bus.q1_data = fwd_data[1];
`else
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^{bus.q0_addr, bus.q1_addr};

  assign bus.q0_hit  = 1'b0;
  assign bus.q0_data = '0;
  assign bus.q1_hit  = 1'b0;
  assign bus.q1_data = '0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_wb_write_arbiter;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_write_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic v0; logic [4:0] r0; logic [31:0] d0;
    logic v1; logic [4:0] r1; logic [31:0] d1;
    logic we; logic [4:0] wa; logic [31:0] wd; logic st;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: writes accepted but not yet presented on rf_*, in program order.
  wr_t         mq[$];
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    bus.wb0_valid = v0; bus.wb0_reg = r0; bus.wb0_data = d0;
    bus.wb1_valid = v1; bus.wb1_reg = r1; bus.wb1_data = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_stall();
    return (int'(DEPTH) - mq.size()) < 2;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_we = 1'b0; m_waddr = '0; m_wdata = '0;
  endtask

  task automatic m_edge(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    bit t0, t1;
    wr_t w;
    t0 = !m_stall() && v0 && (r0 != 0);
    t1 = !m_stall() && v1 && (r1 != 0);
    if (t0 && t1 && r0 == r1) t0 = 0;
    if (t0) mq.push_back('{a: r0, d: d0});
    if (t1) mq.push_back('{a: r1, d: d1});
    if (mq.size() > 0) begin
      w = mq.pop_front();
      m_we = 1'b1; m_waddr = w.a; m_wdata = w.d;
    end else begin
      m_we = 1'b0;
    end
  endtask

  function automatic logic [32:0] m_fwd(input logic [4:0] a);
`ifdef WB_FWD_EN
    if (a == 0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == a) return {1'b1, mq[i].d};
    if (m_we && m_waddr == a) return {1'b1, m_wdata};
`endif
    return {1'b0, a & 5'd0, 28'd0};
  endfunction

  vec_t vt[10];
  wr_t  exp_w[16];
  wr_t  got_w[$];

  initial begin
    int   sent, seen_we;
    logic stall_seen, acc;
    logic [32:0] f0, f1;
    logic v0, v1;
    logic [4:0] r0, r1;
    logic [31:0] d0, d1;

    vt[0] = '{1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5A5A5A5, 1'b0};
    vt[1] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 32'hA5A5A5A5, 1'b0};
    vt[2] = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1, 5'd3, 32'h11, 1'b0};
    vt[3] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h22, 1'b0};
    vt[4] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd4, 32'h22, 1'b0};
    vt[5] = '{1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 1'b1, 5'd7, 32'h2, 1'b0};
    vt[6] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 32'h2, 1'b0};
    vt[7] = '{1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd7, 32'h2, 1'b0};
    vt[8] = '{1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h66, 1'b0};
    vt[9] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd6, 32'h66, 1'b0};

    drive(0, 0, 0, 0, 0, 0);
    bus.q0_addr = '0;
    bus.q1_addr = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset rf_we", bus.rf_we, 0);
    check("reset rf_waddr", bus.rf_waddr, 0);
    check("reset rf_wdata", bus.rf_wdata, 0);
    check("reset stall_wb", bus.stall_wb, 0);
    rst = 1'b0;

    // Directed vectors: single write, dual lanes, collision, $0 drop, lane-0 $0 with lane-1 live.
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].v0, vt[i].r0, vt[i].d0, vt[i].v1, vt[i].r1, vt[i].d1);
      tick();
      check($sformatf("vec%0d rf_we", i), bus.rf_we, vt[i].we);
      check($sformatf("vec%0d rf_waddr", i), bus.rf_waddr, vt[i].wa);
      check($sformatf("vec%0d rf_wdata", i), bus.rf_wdata, vt[i].wd);
      check($sformatf("vec%0d stall_wb", i), bus.stall_wb, vt[i].st);
    end
    drive(0, 0, 0, 0, 0, 0);

    // Back-to-back dual writes: WB holds each pair until accepted.
    for (int i = 0; i < 16; i++) exp_w[i] = '{a: 5'(i + 1), d: 32'h100 * (i + 1)};
    sent = 0;
    stall_seen = 1'b0;
    got_w.delete();
    for (int cyc = 0; cyc < 80 && got_w.size() < 16; cyc++) begin
      if (sent < 16) drive(1, exp_w[sent].a, exp_w[sent].d, 1, exp_w[sent+1].a, exp_w[sent+1].d);
      else drive(0, 0, 0, 0, 0, 0);
      stall_seen = stall_seen | bus.stall_wb;
      acc = !bus.stall_wb && (sent < 16);
      tick();
      if (acc) sent += 2;
      if (bus.rf_we) got_w.push_back('{a: bus.rf_waddr, d: bus.rf_wdata});
    end
    check("burst stall seen", stall_seen, 1);
    check("burst write count", got_w.size(), 16);
    for (int i = 0; i < got_w.size() && i < 16; i++)
      check($sformatf("burst write %0d", i), {got_w[i].a, got_w[i].d}, {exp_w[i].a, exp_w[i].d});
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("burst drained rf_we", bus.rf_we, 0);

    // Reset with three entries queued.
    drive(1, 5'd1, 32'h1, 1, 5'd2, 32'h2); tick();
    drive(1, 5'd3, 32'h3, 1, 5'd4, 32'h4); tick();
    drive(1, 5'd5, 32'h5, 1, 5'd6, 32'h6); tick();
    check("pre-reset stall at 3 queued", bus.stall_wb, 1);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("async reset rf_we", bus.rf_we, 0);
    check("async reset stall_wb", bus.stall_wb, 0);
    check("async reset rf_waddr", bus.rf_waddr, 0);
    tick();
    rst = 1'b0;
    seen_we = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.rf_we) seen_we++;
    end
    check("no write after reset", seen_we, 0);

    // Two pending writes to reg 9: forwarding must return the younger one.
    drive(1, 5'd1, 32'h1, 1, 5'd9, 32'h10); tick();
    drive(1, 5'd9, 32'h20, 1, 5'd10, 32'h30); tick();
    drive(0, 0, 0, 0, 0, 0);
    bus.q0_addr = 5'd9;
    bus.q1_addr = 5'd10;
    #1;
    check("fwd rf stage holds older reg9", {bus.rf_waddr, bus.rf_wdata}, {5'd9, 32'h10});
`ifdef WB_FWD_EN
    check("fwd q0_hit", bus.q0_hit, 1);
    check("fwd q0_data", bus.q0_data, 32'h20);
    check("fwd q1_hit", bus.q1_hit, 1);
    check("fwd q1_data", bus.q1_data, 32'h30);
`else
    check("nofwd q0_hit", bus.q0_hit, 0);
    check("nofwd q0_data", bus.q0_data, 0);
    check("nofwd q1_hit", bus.q1_hit, 0);
`endif
    bus.q0_addr = '0;
    bus.q1_addr = '0;

    // Randomized traffic against the queue model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      r0 = 5'($urandom_range(0, 7));
      r1 = 5'($urandom_range(0, 7));
      d0 = $urandom;
      d1 = $urandom;
      drive(v0, r0, d0, v1, r1, d1);
      bus.q0_addr = 5'($urandom_range(0, 7));
      bus.q1_addr = 5'($urandom_range(0, 7));
      #1;
      check($sformatf("rand%0d stall_wb", cyc), bus.stall_wb, m_stall());
      f0 = m_fwd(bus.q0_addr);
      f1 = m_fwd(bus.q1_addr);
      check($sformatf("rand%0d q0_hit", cyc), bus.q0_hit, f0[32]);
      check($sformatf("rand%0d q1_hit", cyc), bus.q1_hit, f1[32]);
      if (f0[32]) check($sformatf("rand%0d q0_data", cyc), bus.q0_data, f0[31:0]);
      if (f1[32]) check($sformatf("rand%0d q1_data", cyc), bus.q1_data, f1[31:0]);
      @(posedge clk);
      #1;
      m_edge(v0, r0, d0, v1, r1, d1);
      check($sformatf("rand%0d rf_we", cyc), bus.rf_we, m_we);
      check($sformatf("rand%0d rf_waddr", cyc), bus.rf_waddr, m_waddr);
      check($sformatf("rand%0d rf_wdata", cyc), bus.rf_wdata, m_wdata);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
